psum_spad_ctrl: RTL and testbench

Controller that owns the PE's negative-edge psum scratch pad and drives its address, write-enable and write-data pins. It accumulates 16-bit products from the PE multiplier into addressed psum entries with a read-add-write sequence. On request it drains entries 0..drain_len-1 to the downstream psum output with a valid/ready handshake. It is the initiator side of the spad's addr/we/data interface; the spad itself has no reset.

---
 rtl/pe_pkg.sv | 37 +++
 rtl/psum_spad_ctrl_if.sv | 44 ++++
 rtl/psum_acc_add.sv | 21 ++
 rtl/psum_spad_ctrl.sv | 138 +++++++++++++
 tb/tb_psum_spad_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared PE definitions for the psum scratch-pad controller:
//               default sizes, controller state encoding and a saturating
//               signed adder used when PSUM_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int PSUM_DEPTH = 24;
    localparam int PSUM_DW    = 16;
    localparam int PSUM_AW    = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_D_RD  = 3'd3,
        S_D_OUT = 3'd4
    } state_t;

    // Signed add that clamps to the most positive / most negative value when
    // both operands share a sign and the raw sum flips it.
    function automatic logic [PSUM_DW-1:0] sat_add(input logic [PSUM_DW-1:0] a,
                                                   input logic [PSUM_DW-1:0] b);
        logic [PSUM_DW-1:0] s;
        s = a + b;
        if ((a[PSUM_DW-1] == b[PSUM_DW-1]) && (s[PSUM_DW-1] != a[PSUM_DW-1])) begin
            s = a[PSUM_DW-1] ? {1'b1, {(PSUM_DW-1){1'b0}}}
                             : {1'b0, {(PSUM_DW-1){1'b1}}};
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_spad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_spad_ctrl_if
// Description : Bundle of the product input, drain request, psum output and
//               scratch-pad pin signals of the psum scratch-pad controller.
//               master = controller view, slave = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_spad_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 5
) ();
    logic          prod_valid;
    logic          prod_ready;
    logic [DW-1:0] prod_data;
    logic [AW-1:0] prod_idx;
    logic          prod_first;
    logic          drain_start;
    logic [AW-1:0] drain_len;
    logic          psum_out_valid;
    logic          psum_out_ready;
    logic [DW-1:0] psum_out_data;
    logic          drain_done;
    logic          idx_err;
    logic [AW-1:0] spad_addr;
    logic          spad_we;
    logic [DW-1:0] spad_din;
    logic [DW-1:0] spad_dout;

    modport master (
        input  prod_valid, prod_data, prod_idx, prod_first,
        input  drain_start, drain_len, psum_out_ready, spad_dout,
        output prod_ready, psum_out_valid, psum_out_data, drain_done, idx_err,
        output spad_addr, spad_we, spad_din
    );

    modport slave (
        output prod_valid, prod_data, prod_idx, prod_first,
        output drain_start, drain_len, psum_out_ready, spad_dout,
        input  prod_ready, psum_out_valid, psum_out_data, drain_done, idx_err,
        input  spad_addr, spad_we, spad_din
    );
endinterface
`default_nettype wire

// File: rtl/psum_acc_add.sv
`default_nettype none
// ============================================================================
// Module      : psum_acc_add
// Description : Combinational psum accumulate adder. Wraps in two's complement
//               by default; saturates when macro PSUM_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_acc_add
    import pe_pkg::*;
(
    input  wire logic [PSUM_DW-1:0] a,
    input  wire logic [PSUM_DW-1:0] b,
    output logic      [PSUM_DW-1:0] sum
);
`ifdef PSUM_SAT_EN
    assign sum = sat_add(a, b);
`else
    assign sum = a + b;
`endif
endmodule
`default_nettype wire

// File: rtl/psum_spad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_spad_ctrl
// Description : Owns the negedge psum scratch pad. Accumulates products with a
//               read-add-write sequence and drains entries 0..len-1 over a
//               valid/ready output. Optional macro PSUM_SAT_EN selects
//               saturating instead of wrapping accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_spad_ctrl
    import pe_pkg::*;
#(
    parameter int DEPTH = PSUM_DEPTH
) (
    input  wire              clk,
    input  wire              rst_n,
    psum_spad_ctrl_if.master bus
);
    // Datapath width follows the package so the shared adder lines up.
    localparam int DW = PSUM_DW;
    localparam int AW = PSUM_AW;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [DW-1:0] lat_data;
    logic          lat_first;
    logic [AW-1:0] beat;
    logic [AW-1:0] len;
    logic          pending;
    logic          accept;
    logic          idx_ok;
    logic          last_beat;
    logic [DW-1:0] acc_sum;

    assign bus.prod_ready     = (state == S_IDLE) || (state == S_WR);
    assign bus.psum_out_valid = (state == S_D_OUT);

    psum_acc_add u_add (
        .a   (bus.spad_dout),
        .b   (lat_data),
        .sum (acc_sum)
    );

    // Handshake and drain-progress decodes.
    always_comb begin
        accept    = bus.prod_valid && bus.prod_ready;
        idx_ok    = ({1'b0, bus.prod_idx} < DEPTH_LIM);
        last_beat = (beat == (len - 1'b1));
    end

    // Next-state: products beat a pending drain; bad indices fall back to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WR: begin
                if (accept)       state_nxt = idx_ok ? S_RD : S_IDLE;
                else if (pending) state_nxt = S_D_RD;
                else              state_nxt = S_IDLE;
            end
            S_RD:    state_nxt = S_WR;
            S_D_RD:  state_nxt = S_D_OUT;
            S_D_OUT: if (bus.psum_out_ready) state_nxt = last_beat ? S_IDLE : S_D_RD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Scratch-pad pins, product latch, drain counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spad_addr     <= '0;
            bus.spad_we       <= 1'b0;
            bus.spad_din      <= '0;
            bus.psum_out_data <= '0;
            bus.drain_done    <= 1'b0;
            bus.idx_err       <= 1'b0;
            lat_data          <= '0;
            lat_first         <= 1'b0;
            beat              <= '0;
        end else begin
            bus.drain_done <= 1'b0;
            case (state)
                S_IDLE, S_WR: begin
                    bus.spad_we <= 1'b0;
                    if (accept) begin
                        if (idx_ok) begin
                            bus.spad_addr <= bus.prod_idx;
                            lat_data      <= bus.prod_data;
                            lat_first     <= bus.prod_first;
                        end else begin
                            bus.idx_err   <= 1'b1;
                        end
                    end else if (pending) begin
                        beat          <= '0;
                        bus.spad_addr <= '0;
                    end
                end
                S_RD: begin
                    // spad_dout holds the entry read at the intervening negedge.
                    bus.spad_din <= lat_first ? lat_data : acc_sum;
                    bus.spad_we  <= 1'b1;
                end
                S_D_RD: bus.psum_out_data <= bus.spad_dout;
                S_D_OUT: begin
                    if (bus.psum_out_ready) begin
                        if (last_beat) begin
                            bus.drain_done <= 1'b1;
                        end else begin
                            beat          <= beat + 1'b1;
                            bus.spad_addr <= beat + 1'b1;
                        end
                    end
                end
                default: bus.spad_we <= 1'b0;
            endcase
        end
    end

    // Drain request flag; a request while one is outstanding is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            len     <= '0;
        end else if ((state == S_D_OUT) && bus.psum_out_ready && last_beat) begin
            pending <= 1'b0;
        end else if (bus.drain_start && !pending) begin
            pending <= 1'b1;
            len     <= (bus.drain_len == '0) ? AW'(1) : bus.drain_len;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_spad_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_psum_spad_ctrl
// Description : Self-checking bench for psum_spad_ctrl with a negedge
//               scratch-pad model and an entry-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_spad_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

`ifdef PSUM_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] OVF_EXP = 16'h8000;
`endif

    psum_spad_ctrl_if #(.DW(16), .AW(5)) bus ();

    psum_spad_ctrl #(.DEPTH(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scratch pad: samples addr/we/din on the falling edge, write-first.
    logic [15:0] spad_mem [0:31];
    initial begin
        for (int k = 0; k < 32; k++) spad_mem[k] = '0;
        bus.spad_dout = '0;
    end
    always @(negedge clk) begin
        if (bus.spad_we) spad_mem[bus.spad_addr] = bus.spad_din;
        bus.spad_dout = spad_mem[bus.spad_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          exp_mem [0:23];
    bit          exp_err, m_pend, exp_done, last_stall;
    int          m_len, m_beat;
    logic [15:0] last_data;
    logic [15:0] beats_q [$];

    initial for (int k = 0; k < 24; k++) exp_mem[k] = 0;

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int madd(input int acc, input int p);
        int s;
        s = sx(acc) + sx(p);
`ifdef PSUM_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s & 32'hFFFF;
    endfunction

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_err = 0; m_pend = 0; m_beat = 0; exp_done = 0; last_stall = 0;
        end else begin
            chk("drain_done", bus.drain_done, exp_done);
            exp_done = 0;
            chk("idx_err", bus.idx_err, exp_err);
            if (bus.spad_we) chk("we_addr_range", bus.spad_addr < 5'd24, 1);
            if (bus.psum_out_valid) begin
                chk("prod_ready_in_drain", bus.prod_ready, 0);
                if (last_stall) chk("stall_hold", bus.psum_out_data, last_data);
                chk("beat_expected", m_pend && (m_beat < m_len), 1);
                if (m_pend && m_beat < m_len)
                    chk("psum_data", bus.psum_out_data, exp_mem[m_beat]);
                last_data  = bus.psum_out_data;
                last_stall = !bus.psum_out_ready;
                if (bus.psum_out_ready) begin
                    if (m_beat == m_len - 1) begin
                        exp_done = 1;
                        m_pend   = 0;
                    end
                    m_beat++;
                end
            end else begin
                last_stall = 0;
            end
            if (bus.prod_valid && bus.prod_ready) begin
                if (bus.prod_idx >= 5'd24) exp_err = 1;
                else if (bus.prod_first) exp_mem[bus.prod_idx] = int'(bus.prod_data);
                else exp_mem[bus.prod_idx] = madd(exp_mem[bus.prod_idx], int'(bus.prod_data));
            end
            if (bus.drain_start && !m_pend) begin
                m_pend = 1;
                m_len  = (bus.drain_len == 0) ? 1 : int'(bus.drain_len);
                m_beat = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] d, input logic [4:0] idx, input bit first,
                        output int acc_cyc);
        bit got;
        got = 0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = d;
        bus.prod_idx   = idx;
        bus.prod_first = first;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.prod_ready) got = 1;
            @(posedge clk); #1;
        end
        acc_cyc = cyc;
        chk("send_handshake", got, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int len, input bit use_pat, output int gap);
        bit          done, seen;
        int          t0;
        logic [3:0]  pat;
        pat  = 4'b1001;  // bit k = ready in cycle k: 1,0,0,1
        done = 0; seen = 0; gap = -1;
        beats_q.delete();
        bus.drain_start = 1'b1;
        bus.drain_len   = 5'(len);
        @(posedge clk); #1;
        bus.drain_start = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (bus.psum_out_valid && !seen) begin seen = 1; gap = cyc - t0; end
            if (bus.psum_out_valid && bus.psum_out_ready) beats_q.push_back(bus.psum_out_data);
            if (bus.drain_done) done = 1;
            @(posedge clk); #1;
            if (use_pat) bus.psum_out_ready = pat[(k + 1) % 4];
        end
        chk("drain_done_seen", done, 1);
        bus.psum_out_ready = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a, prev, gap;
        bus.prod_valid = 0; bus.prod_data = 0; bus.prod_idx = 0; bus.prod_first = 0;
        bus.drain_start = 0; bus.drain_len = 0; bus.psum_out_ready = 1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_prod_ready", bus.prod_ready, 1);
        chk("rst_out_valid", bus.psum_out_valid, 0);
        chk("rst_spad_we", bus.spad_we, 0);
        chk("rst_spad_addr", bus.spad_addr, 0);
        chk("rst_spad_din", bus.spad_din, 0);
        chk("rst_out_data", bus.psum_out_data, 0);
        chk("rst_idx_err", bus.idx_err, 0);
        chk("rst_drain_done", bus.drain_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        // 5 then +7 at entry 3
        send(16'd5, 5'd3, 1'b1, a);
        bus.prod_valid = 0;
        @(negedge clk); chk("t1_ready_rd", bus.prod_ready, 0);
        @(negedge clk); chk("t1_ready_wr", bus.prod_ready, 1);
        @(posedge clk); #1;
        send(16'd7, 5'd3, 1'b0, a);
        bus.prod_valid = 0;
        idle(3);
        drain(4, 1'b0, gap);
        chk("t1_first_valid_gap", gap, 2);
        chk("t1_beats", beats_q.size(), 4);
        chk("t1_entry3", beats_q[3], 16'd12);

        // ten back-to-back products of 1 at entry 0
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            send(16'd1, 5'd0, (k == 0), a);
            if (k > 0) chk("t2_spacing", a - prev, 2);
            prev = a;
        end
        bus.prod_valid = 0;
        idle(3);
        drain(1, 1'b0, gap);
        chk("t2_entry0", beats_q[0], 16'd10);

        // signed overflow at entry 2
        send(16'h7FFF, 5'd2, 1'b1, a);
        send(16'h0001, 5'd2, 1'b0, a);
        bus.prod_valid = 0;
        idle(3);
        drain(3, 1'b0, gap);
        chk("t3_entry0", beats_q[0], 16'd10);
        chk("t3_overflow", beats_q[2], OVF_EXP);

        // out-of-range index
        send(16'h1234, 5'd24, 1'b1, a);
        bus.prod_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("t4_no_we", bus.spad_we, 0);
        end
        chk("t4_idx_err", bus.idx_err, 1);
        idle(5);
        @(negedge clk); chk("t4_idx_err_sticky", bus.idx_err, 1);
        @(posedge clk); #1;

        // stalled drain, ready 1,0,0,1
        drain(3, 1'b1, gap);
        chk("t5_beats", beats_q.size(), 3);
        chk("t5_entry2", beats_q[2], OVF_EXP);
        chk("t5_idx_err_sticky", bus.idx_err, 1);

        // reset while presenting a psum
        bus.psum_out_ready = 0;
        bus.drain_start = 1; bus.drain_len = 5'd2;
        @(posedge clk); #1 bus.drain_start = 0;
        for (int k = 0; k < 10 && !bus.psum_out_valid; k++) @(negedge clk);
        chk("t6_in_dout", bus.psum_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_async", bus.psum_out_valid, 0);
        chk("t6_ready_in_reset", bus.prod_ready, 1);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        bus.psum_out_ready = 1;
        @(negedge clk);
        chk("t6_ready_after", bus.prod_ready, 1);
        chk("t6_valid_after", bus.psum_out_valid, 0);
        chk("t6_idx_err_clr", bus.idx_err, 0);
        idle(4);

        // post-reset sanity: entry 5 written and drained
        send(16'd3, 5'd5, 1'b1, a);
        bus.prod_valid = 0;
        idle(3);
        drain(6, 1'b0, gap);
        chk("t7_entry5", beats_q[5], 16'd3);
        chk("t7_entry3", beats_q[3], 16'd12);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
